hack_ctrl_mc: RTL and testbench
===============================

Name: hack_ctrl_mc

Overview:
Multi-cycle, parametrised successor to the Hack CPU control unit. It sequences fetch, optional memory read, execute and optional memory write through a state machine, using ready-based handshakes to instruction ROM and data RAM. This lets the CPU run against wait-stated memories instead of single-cycle ones. It owns the A, D and PC registers, drives the external combinational ALU, and detects a self-loop halt.

Parameters:
DATA_W, 16, width of A/D registers, instruction, ALU and data bus
ADDR_W, 15, width of pc and addressM; must be ≤ DATA_W-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
fetch_req  output  1  instruction fetch request at address pc
pc  output  ADDR_W  program counter / ROM address
instr_valid  input  1  instruction present this cycle; sampled only in FETCH
instruction  input  DATA_W  instruction word
mem_req  output  1  data memory access request
writeM  output  1  1 = write, 0 = read; meaningful only with mem_req
addressM  output  ADDR_W  data memory address
outM  output  DATA_W  write data, registered
inM  input  DATA_W  read data; valid with m_ready during a read
m_ready  input  1  access completes this cycle
x_alu_in  output  DATA_W  ALU x operand (D)
y_alu_in  output  DATA_W  ALU y operand (A or M buffer)
alu_op  output  6  instruction bits [11:6] of IR
alu_out  input  DATA_W  ALU result
ng  input  1  ALU result negative
zr  input  1  ALU result zero
halted  output  1  sticky halt flag

Behaviour:
- Reset state (async, while rst=1): state=FETCH; IR, A, D, Mbuf, pc, outM, addressM = 0; halted=0; mem_req=0; writeM=0; fetch_req=0 (gated by rst).
- States: FETCH, MRD, EXEC, MWR, HALT.
- Instruction fields are decoded from IR: bit15 selects C vs A; a=IR[12]; ddd=IR[5:3]; jjj=IR[2:0]. Upper bits use DATA_W-1 as the type bit; the C-field positions are fixed.
- FETCH: fetch_req=1. On instr_valid, latch IR. Next state is MRD if the instruction is C with a=1, otherwise EXEC. No advance without instr_valid (unbounded wait).
- MRD: mem_req=1, writeM=0, addressM=A[ADDR_W-1:0]. On m_ready, Mbuf<=inM and go to EXEC.
- EXEC (exactly 1 cycle):
  - x_alu_in=D; y_alu_in = a ? Mbuf : A.
  - A-instruction: A<=IR, pc<=pc+1.
  - C-instruction:
    - if d2, A<=alu_out; if d1, D<=alu_out.
    - if d0, outM<=alu_out, addressM<=old A, go to MWR.
    - Jump condition uses ng/zr sampled this cycle.
    - If taken, pc<=old A[ADDR_W-1:0]; otherwise pc<=pc+1.
- Old-A rule: the write address and jump target always use A from before the EXEC update (e.g. AM=M+1 writes to the old address).
- MWR: mem_req=1, writeM=1; outM and addressM are held stable until m_ready, then go to FETCH (or HALT if halt is pending).
- Halt: in EXEC, a C-instruction with jjj=111 and old A[ADDR_W-1:0]==pc sets halt pending. Any pending MWR completes first, then the block enters HALT.
  - In HALT: halted=1, no requests.
  - HALT exits only on rst.
- pc+1 wraps modulo 2^ADDR_W (max→0).
- instr_valid outside FETCH and m_ready while mem_req=0 are ignored.
- rst mid-MRD/MWR: mem_req and writeM drop immediately and the access is abandoned.
- Minimum latency per instruction:
  - A-instruction: 2 cycles.
  - C-instruction: 2 cycles, plus 1+ for an M read, plus 1+ for an M write.

Optional Feature:
HACK_CTRL_PERF_EN: adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
- retired_cnt increments once per instruction on its final state exit (EXEC without write, or MWR on m_ready).
- stall_cnt increments on every cycle in FETCH with instr_valid=0, or in MRD/MWR with m_ready=0.
- Without the macro, neither port nor counter exists.

Test Plan:
- Reset: hold rst 3 cycles, then release → pc=0, halted=0, mem_req=0, fetch_req=1 on the first cycle after release.
- Program 0x0015 then 0xEC10 (D=A), instr_valid delayed 3 cycles each → A=21, D=21, pc=2; no state advance while instr_valid=0.
- D=5, A=100, 0xF088 (M=D+M); RAM returns 7 with m_ready after 2 cycles and accepts the write after 3 cycles → write of 12 to address 100; writeM/outM/addressM stable throughout the wait.
- A=50, mem[50]=9, 0xFDE8 (AM=M+1) → write 10 to address 50 (old A); afterwards A=10.
- A=8, 0xE302 (D;JEQ): with D=0 → pc=8; with D=1 → pc=pc+1. Repeat with pc at 2^ADDR_W-1 and not taken → pc wraps to 0.
- At pc=4: @4 (0x0004), then 0xEA87 (0;JMP) → halted=1 after EXEC, fetch_req stays 0 for 20 cycles, rst clears halted. With HACK_CTRL_PERF_EN, retired_cnt equals the instruction count of each scenario.

Source files
------------

// File: rtl/hack_ctrl_mc.sv
// Multi-cycle Hack CPU control unit: FETCH / MRD / EXEC / MWR / HALT over ready-handshaked ROM and RAM.
// Optional feature macro HACK_CTRL_PERF_EN adds retired_cnt and stall_cnt performance counters.
module hack_ctrl_mc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instruction,
  output logic              mem_req,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [DATA_W-1:0] outM,
  input  logic [DATA_W-1:0] inM,
  input  logic              m_ready,
  output logic [DATA_W-1:0] x_alu_in,
  output logic [DATA_W-1:0] y_alu_in,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              ng,
  input  logic              zr,
  output logic              halted
`ifdef HACK_CTRL_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_MRD   = 3'd1,
    S_EXEC  = 3'd2,
    S_MWR   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic [DATA_W-1:0]   mbuf_q, mbuf_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                halt_pend_q, halt_pend_d;

  // IR decode; C-field positions are fixed regardless of DATA_W
  logic              is_c;
  logic              a_bit;
  logic [2:0]        ddd;
  logic [2:0]        jjj;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic              jump_take;
  logic              halt_hit;

  assign is_c      = ir_q[DATA_W-1];
  assign a_bit     = ir_q[12];
  assign ddd       = ir_q[5:3];
  assign jjj       = ir_q[2:0];
  assign a_addr    = a_q[ADDR_W-1:0];
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign jump_take = (jjj[2] & ng) | (jjj[1] & zr) | (jjj[0] & ~ng & ~zr);
  assign halt_hit  = (jjj == 3'b111) && (a_addr == pc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      a_q         <= '0;
      d_q         <= '0;
      mbuf_q      <= '0;
      out_q       <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      d_q         <= d_d;
      mbuf_q      <= mbuf_d;
      out_q       <= out_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state and datapath updates; write address and jump target use A before the EXEC update
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    d_d         = d_q;
    mbuf_d      = mbuf_q;
    out_d       = out_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    halt_pend_d = halt_pend_q;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d = instruction;
          if (instruction[DATA_W-1] && instruction[12]) begin
            addr_d  = a_addr;
            state_d = S_MRD;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_MRD: begin
        if (m_ready) begin
          mbuf_d  = inM;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (!is_c) begin
          a_d  = ir_q;
          pc_d = pc_inc;
        end else begin
          if (ddd[2]) a_d = alu_out;
          if (ddd[1]) d_d = alu_out;
          pc_d = jump_take ? a_addr : pc_inc;
          if (ddd[0]) begin
            out_d       = alu_out;
            addr_d      = a_addr;
            halt_pend_d = halt_hit;
            state_d     = S_MWR;
          end else if (halt_hit) begin
            state_d = S_HALT;
          end
        end
      end
      S_MWR: begin
        if (m_ready) begin
          halt_pend_d = 1'b0;
          state_d     = halt_pend_q ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign fetch_req = (state_q == S_FETCH) && !rst;
  assign mem_req   = (state_q == S_MRD) || (state_q == S_MWR);
  assign writeM    = (state_q == S_MWR);
  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;
  assign addressM  = addr_q;
  assign outM      = out_q;
  assign x_alu_in  = d_q;
  assign y_alu_in  = a_bit ? mbuf_q : a_q;
  assign alu_op    = ir_q[11:6];

`ifdef HACK_CTRL_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Retire on the last state of each instruction; stall on every unanswered handshake cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (((state_q == S_EXEC) && (state_d != S_MWR)) || ((state_q == S_MWR) && m_ready))
        retired_q <= retired_q + 32'd1;
      if (((state_q == S_FETCH) && !instr_valid) ||
          (((state_q == S_MRD) || (state_q == S_MWR)) && !m_ready))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_hack_ctrl_mc.sv
// Bench for hack_ctrl_mc: instruction-level Hack model plus ROM/RAM/ALU environment, directed and random programs.
module tb_hack_ctrl_mc;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk, rst;
  logic          fetch_req, instr_valid, mem_req, writeM, m_ready, ng, zr, halted;
  logic [AW-1:0] pc, addressM;
  logic [DW-1:0] instruction, outM, inM, x_alu_in, y_alu_in, alu_out;
  logic [5:0]    alu_op;
`ifdef HACK_CTRL_PERF_EN
  logic [31:0]   retired_cnt, stall_cnt;
`endif

  hack_ctrl_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc),
    .instr_valid(instr_valid), .instruction(instruction),
    .mem_req(mem_req), .writeM(writeM), .addressM(addressM), .outM(outM),
    .inM(inM), .m_ready(m_ready), .x_alu_in(x_alu_in), .y_alu_in(y_alu_in),
    .alu_op(alu_op), .alu_out(alu_out), .ng(ng), .zr(zr), .halted(halted)
`ifdef HACK_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack ALU: zx nx zy ny f no
  function automatic logic [DW-1:0] alu(input logic [5:0] op, input logic [DW-1:0] xi,
                                        input logic [DW-1:0] yi);
    logic [DW-1:0] x, y, r;
    x = op[5] ? '0 : xi;
    if (op[4]) x = ~x;
    y = op[3] ? '0 : yi;
    if (op[2]) y = ~y;
    r = op[1] ? x + y : x & y;
    if (op[0]) r = ~r;
    return r;
  endfunction

  assign alu_out = alu(alu_op, x_alu_in, y_alu_in);
  assign ng      = alu_out[DW-1];
  assign zr      = (alu_out == '0);

  logic [DW-1:0] rom     [DEPTH];
  logic [DW-1:0] env_ram [DEPTH];
  logic [DW-1:0] m_ram   [DEPTH];

  int            vecs, errs;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_a, m_d;
  bit            m_halt;
  int            m_steps, limit;
  bit            inflight, rd_seen, wr_seen, ex_seen, exp_rd, exp_wr, exp_c, halt_seen;
  logic [AW-1:0] exp_raddr, exp_waddr;
  logic [DW-1:0] exp_wdata, exp_x, exp_y;
  logic [5:0]    exp_op;
  bit            fixed;
  int            iv_dly, rd_dly, wr_dly, fw, mw;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One full instruction at ISA level, with signed arithmetic for the jump decision
  task automatic model_step(input logic [DW-1:0] ins);
    logic [DW-1:0] y, r, old_a;
    logic take;
    m_steps++;
    exp_c  = ins[DW-1];
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    exp_x  = m_d;
    exp_op = ins[11:6];
    if (!ins[DW-1]) begin
      m_a  = ins;
      m_pc = m_pc + AW'(1);
    end else begin
      old_a     = m_a;
      exp_rd    = ins[12];
      exp_raddr = AW'(old_a);
      y         = ins[12] ? m_ram[AW'(old_a)] : old_a;
      exp_y     = y;
      r         = alu(ins[11:6], m_d, y);
      take      = (ins[2] && ($signed(r) < 0)) || (ins[1] && (r == 0)) ||
                  (ins[0] && ($signed(r) > 0));
      if (ins[5]) m_a = r;
      if (ins[4]) m_d = r;
      if (ins[3]) begin
        exp_wr    = 1'b1;
        exp_waddr = AW'(old_a);
        exp_wdata = r;
        m_ram[AW'(old_a)] = r;
      end
      if ((ins[2:0] == 3'b111) && (AW'(old_a) == m_pc)) m_halt = 1'b1;
      m_pc = take ? AW'(old_a) : m_pc + AW'(1);
    end
  endtask

  // Compare DUT against the model for this cycle, then drive the environment for the next edge
  task automatic cycle();
    if (halted || fetch_req) begin
      if (inflight) begin
        chk("seq", {29'b0, rd_seen, wr_seen, ex_seen}, {29'b0, exp_rd, exp_wr, 1'b1});
        inflight = 1'b0;
      end
      if (halted) begin
        chk("halt_state", 32'(m_halt), 32'd1);
        chk("halt_quiet", 32'({fetch_req, mem_req}), 32'd0);
        halt_seen = 1'b1;
      end else begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("halt_missed", 32'(m_halt), 32'd0);
      end
    end else if (mem_req) begin
      if (!writeM) begin
        chk("rd_expected", 32'(exp_rd), 32'd1);
        chk("rd_addr", 32'(addressM), 32'(exp_raddr));
        rd_seen = 1'b1;
      end else begin
        chk("wr_expected", 32'(exp_wr), 32'd1);
        chk("wr_addr", 32'(addressM), 32'(exp_waddr));
        chk("wr_data", 32'(outM), 32'(exp_wdata));
        wr_seen = 1'b1;
      end
    end else begin
      chk("exec_once", {30'b0, ex_seen, inflight}, 32'd1);
      ex_seen = 1'b1;
      if (exp_c) begin
        chk("alu_x", 32'(x_alu_in), 32'(exp_x));
        chk("alu_y", 32'(y_alu_in), 32'(exp_y));
        chk("alu_op", 32'(alu_op), 32'(exp_op));
      end
    end

    if (fetch_req) begin
      instr_valid = fixed ? (fw >= iv_dly) : 1'($urandom_range(0, 1));
      if (m_halt || (m_steps >= limit)) instr_valid = 1'b0;
      fw++;
      instruction = rom[pc];
      if (instr_valid) begin
        model_step(rom[m_pc]);
        fw       = 0;
        inflight = 1'b1;
        rd_seen  = 1'b0;
        wr_seen  = 1'b0;
        ex_seen  = 1'b0;
      end
    end else begin
      instr_valid = fixed ? 1'b0 : 1'($urandom_range(0, 1));
      instruction = DW'($urandom);
    end

    if (mem_req) begin
      m_ready = fixed ? (mw >= (writeM ? wr_dly : rd_dly)) : 1'($urandom_range(0, 1));
      mw      = m_ready ? 0 : mw + 1;
      inM     = writeM ? DW'($urandom) : env_ram[addressM];
      if (m_ready && writeM) begin
        env_ram[addressM] = outM;
        last_wr_addr      = addressM;
        last_wr_data      = outM;
      end
    end else begin
      m_ready = fixed ? 1'b0 : 1'($urandom_range(0, 1));
      mw      = 0;
      inM     = DW'($urandom);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    instr_valid = 1'b0;
    m_ready     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gate", 32'({fetch_req, mem_req, writeM, halted}), 32'd0);
    m_pc = '0; m_a = '0; m_d = '0; m_halt = 1'b0; m_steps = 0;
    inflight = 1'b0; halt_seen = 1'b0; fw = 0; mw = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic run(input int n, input int budget);
    int cyc;
    cyc   = 0;
    limit = n;
    do_reset();
    while (!halt_seen && !((m_steps >= limit) && !inflight)) begin
      if (cyc >= budget) begin
        vecs++;
        errs++;
        $display("FAIL timeout: %0d cycles, %0d of %0d instructions", cyc, m_steps, n);
        break;
      end
      cycle();
      cyc++;
    end
`ifdef HACK_CTRL_PERF_EN
    chk("retired_cnt", retired_cnt, 32'(m_steps));
`endif
  endtask

  task automatic clear_mem();
    for (int i = 0; i < int'(DEPTH); i++) begin
      rom[i] = '0; env_ram[i] = '0; m_ram[i] = '0;
    end
  endtask

  task automatic set_ram(input int addr, input logic [DW-1:0] v);
    env_ram[addr] = v;
    m_ram[addr]   = v;
  endtask

  initial begin
    vecs = 0; errs = 0; rst = 1'b1; instr_valid = 1'b0; m_ready = 1'b0;
    instruction = '0; inM = '0; fixed = 1'b1; iv_dly = 0; rd_dly = 0; wr_dly = 0;
    limit = 0; last_wr_addr = '0; last_wr_data = '0;
    clear_mem();

    // Reset values on the first cycle after release
    limit = 0;
    do_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd1);

    // @21 ; D=A with 3-cycle fetch latency
    clear_mem();
    rom[0] = 16'h0015; rom[1] = 16'hEC10;
    iv_dly = 3;
    run(2, 100);
    chk("s1_pc", 32'(pc), 32'd2);
    chk("s1_model_a", 32'(m_a), 32'd21);
    chk("s1_model_d", 32'(m_d), 32'd21);

    // D=5, A=100, M=D+M with waited read and write
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hF088;
    set_ram(100, 16'd7);
    iv_dly = 0; rd_dly = 2; wr_dly = 3;
    run(4, 200);
    chk("s2_wr_addr", 32'(last_wr_addr), 32'd100);
    chk("s2_wr_data", 32'(last_wr_data), 32'd12);
    chk("s2_ram", 32'(env_ram[100]), 32'd12);

    // AM=M+1 writes through the old A
    clear_mem();
    rom[0] = 16'h0032; rom[1] = 16'hFDE8;
    set_ram(50, 16'd9);
    rd_dly = 1; wr_dly = 1;
    run(2, 100);
    chk("s3_ram", 32'(env_ram[50]), 32'd10);
    chk("s3_wr_addr", 32'(last_wr_addr), 32'd50);
    chk("s3_model_a", 32'(m_a), 32'd10);

    // D;JEQ taken with D=0, not taken with D=1
    clear_mem();
    rom[0] = 16'h0000; rom[1] = 16'hEC10; rom[2] = 16'h0008; rom[3] = 16'hE302;
    run(4, 100);
    chk("s4_jeq_taken", 32'(pc), 32'd8);
    rom[0] = 16'h0001;
    run(4, 100);
    chk("s4_jeq_fall", 32'(pc), 32'd4);

    // Not-taken at pc = 2^AW-1 wraps to 0
    rom[2] = 16'h7FFF; rom[3] = 16'hEA87; rom[DEPTH-1] = 16'hE302;
    run(5, 100);
    chk("s4_wrap_pc", 32'(pc), 32'd0);
    chk("s4_wrap_model", 32'(m_pc), 32'd0);

    // Self-loop 0;JMP at pc=4 halts; stays quiet; reset clears
    clear_mem();
    rom[3] = 16'h0004; rom[4] = 16'hEA87;
    run(10, 200);
    chk("s5_halted", 32'(halted), 32'd1);
    chk("s5_steps", 32'(m_steps), 32'd5);
    for (int i = 0; i < 20; i++) begin
      chk("s5_no_fetch", 32'(fetch_req), 32'd0);
      cycle();
    end
    rst = 1'b1;
    #1;
    chk("s5_rst_clears", 32'(halted), 32'd0);

    // Reset in the middle of an M read abandons the access at once
    clear_mem();
    rom[0] = 16'h0064; rom[1] = 16'hFC10;
    rd_dly = 50;
    limit  = 2;
    do_reset();
    for (int i = 0; i < 100 && !mem_req; i++) cycle();
    chk("mid_rd_active", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rd_drop", 32'({fetch_req, mem_req, writeM}), 32'd0);

    // Random programs with random handshake timing and spurious handshakes
    fixed = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rom[i] = ($urandom_range(0, 1) == 0) ? {1'b0, 15'($urandom_range(0, 63))}
                                             : {3'b111, 13'($urandom)};
        set_ram(i, DW'($urandom_range(0, 15)));
      end
      run(400, 20000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
